// File: rtl/axi_pipeline_pkg.sv
// rtl/axi_pipeline_pkg.sv - payload widths and outstanding-counter helper for the AXI4 pipeline
package axi_pipeline_pkg;

    localparam int MAX_LEVEL = 8;
    localparam int CNT_W     = 8;

    function automatic int aw_payload_w(input int addr_w, input int id_w);
        return addr_w + id_w + 8 + 3 + 2;
    endfunction

    function automatic int w_payload_w(input int data_w, input int strb_w);
        return data_w + strb_w + 1;
    endfunction

    function automatic int r_payload_w(input int data_w, input int id_w);
        return data_w + 1 + id_w + 2;
    endfunction

    function automatic int b_payload_w(input int id_w);
        return 2 + id_w;
    endfunction

    // Returns {underflow, next_count}; a lone decrement at zero saturates and flags underflow.
    function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                                input logic dec);
        logic [CNT_W:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            res = {1'b0, cnt + CNT_W'(1)};
        end else if (dec && !inc) begin
            if (cnt == '0) res = {1'b1, cnt};
            else           res = {1'b0, cnt - CNT_W'(1)};
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_pipeline_ot_skid_stage.sv
// rtl/axi_pipeline_ot_skid_stage.sv - full-throughput register slice and a chain of them
module axi_skid_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);
    logic                  main_valid_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic                  s_fire;
    logic                  main_free;

    assign s_ready   = !skid_valid_q;
    assign m_valid   = main_valid_q;
    assign m_data    = main_data_q;
    assign s_fire    = s_valid && !skid_valid_q;
    assign main_free = !main_valid_q || m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_free) begin
            main_valid_q <= skid_valid_q || s_fire;
            skid_valid_q <= 1'b0;
        end else if (s_fire) begin
            skid_valid_q <= 1'b1;
        end
    end

    // Payload is left unreset; only the valid flags qualify it.
    always_ff @(posedge clk) begin
        if (main_free) begin
            main_data_q <= skid_valid_q ? skid_data_q : s_data;
        end else if (s_fire) begin
            skid_data_q <= s_data;
        end
    end
endmodule

module axi_slice_chain #(
    parameter int WIDTH = 8,
    parameter int LEVEL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             empty
);
    generate
        if (LEVEL == 0) begin : g_wire
            assign m_valid = s_valid;
            assign s_ready = m_ready;
            assign m_data  = s_data;
            assign empty   = 1'b1;
        end else begin : g_pipe
            logic             v [0:LEVEL];
            logic             r [0:LEVEL];
            logic [WIDTH-1:0] d [0:LEVEL];

            assign v[0]     = s_valid;
            assign d[0]     = s_data;
            assign s_ready  = r[0];
            assign m_valid  = v[LEVEL];
            assign m_data   = d[LEVEL];
            assign r[LEVEL] = m_ready;

            for (genvar i = 0; i < LEVEL; i++) begin : g_stage
                axi_skid_stage #(.DATA_WIDTH(WIDTH)) u_stage (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .s_valid (v[i]),
                    .s_ready (r[i]),
                    .s_data  (d[i]),
                    .m_valid (v[i+1]),
                    .m_ready (r[i+1]),
                    .m_data  (d[i+1])
                );
            end

            always_comb begin
                empty = 1'b1;
                for (int i = 1; i <= LEVEL; i++) begin
                    if (v[i]) empty = 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/axi_pipeline_ot.sv
// rtl/axi_pipeline_ot.sv - per-channel AXI4 register-slice pipeline with outstanding-burst limiters
module axi_pipeline_ot
    import axi_pipeline_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH    = 1,
    parameter int C_M_AXI_ADDR_WIDTH  = 32,
    parameter int C_M_AXI_DATA_WIDTH  = 512,
    parameter int C_M_AXI_WSTRB_WIDTH = C_M_AXI_DATA_WIDTH / 8,
    parameter int AW_LEVEL = 3,
    parameter int W_LEVEL  = 3,
    parameter int AR_LEVEL = 3,
    parameter int R_LEVEL  = 3,
    parameter int B_LEVEL  = 3,
    parameter int MAX_RD_OUTSTANDING = 16,
    parameter int MAX_WR_OUTSTANDING = 16
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           in_AWVALID,
    output logic                           in_AWREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_AWADDR,
    input  logic [1:0]                     in_AWBURST,
    input  logic [7:0]                     in_AWLEN,
    input  logic [2:0]                     in_AWSIZE,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    in_AWID,
    input  logic                           in_WVALID,
    output logic                           in_WREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]  in_WDATA,
    input  logic [C_M_AXI_WSTRB_WIDTH-1:0] in_WSTRB,
    input  logic                           in_WLAST,
    output logic                           in_BVALID,
    input  logic                           in_BREADY,
    output logic [1:0]                     in_BRESP,
    output logic [C_M_AXI_ID_WIDTH-1:0]    in_BID,
    input  logic                           in_ARVALID,
    output logic                           in_ARREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_ARADDR,
    input  logic [1:0]                     in_ARBURST,
    input  logic [7:0]                     in_ARLEN,
    input  logic [2:0]                     in_ARSIZE,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    in_ARID,
    output logic                           in_RVALID,
    input  logic                           in_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]  in_RDATA,
    output logic                           in_RLAST,
    output logic [C_M_AXI_ID_WIDTH-1:0]    in_RID,
    output logic [1:0]                     in_RRESP,
    output logic                           out_AWVALID,
    input  logic                           out_AWREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_AWADDR,
    output logic [1:0]                     out_AWBURST,
    output logic [7:0]                     out_AWLEN,
    output logic [2:0]                     out_AWSIZE,
    output logic [C_M_AXI_ID_WIDTH-1:0]    out_AWID,
    output logic                           out_WVALID,
    input  logic                           out_WREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]  out_WDATA,
    output logic [C_M_AXI_WSTRB_WIDTH-1:0] out_WSTRB,
    output logic                           out_WLAST,
    input  logic                           out_BVALID,
    output logic                           out_BREADY,
    input  logic [1:0]                     out_BRESP,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    out_BID,
    output logic                           out_ARVALID,
    input  logic                           out_ARREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_ARADDR,
    output logic [1:0]                     out_ARBURST,
    output logic [7:0]                     out_ARLEN,
    output logic [2:0]                     out_ARSIZE,
    output logic [C_M_AXI_ID_WIDTH-1:0]    out_ARID,
    input  logic                           out_RVALID,
    output logic                           out_RREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]  out_RDATA,
    input  logic                           out_RLAST,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    out_RID,
    input  logic [1:0]                     out_RRESP,
    output logic [CNT_W-1:0]               rd_outstanding,
    output logic [CNT_W-1:0]               wr_outstanding,
    output logic                           idle,
    output logic                           err_underflow
);
    localparam int AX_W = aw_payload_w(C_M_AXI_ADDR_WIDTH, C_M_AXI_ID_WIDTH);
    localparam int W_W  = w_payload_w(C_M_AXI_DATA_WIDTH, C_M_AXI_WSTRB_WIDTH);
    localparam int R_W  = r_payload_w(C_M_AXI_DATA_WIDTH, C_M_AXI_ID_WIDTH);
    localparam int B_W  = b_payload_w(C_M_AXI_ID_WIDTH);

    logic aw_pipe_ready, ar_pipe_ready;
    logic aw_empty, w_empty, ar_empty, r_empty, b_empty;
    logic aw_s_valid, ar_s_valid;

    logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;
    logic [CNT_W:0]   rd_nxt, wr_nxt;
    logic             idle_q, err_q;
    logic             rd_room, wr_room;

    // Limiters only look at registered state so READY never depends on in_RREADY/in_BREADY.
    assign rd_room    = rd_cnt_q < CNT_W'(MAX_RD_OUTSTANDING);
    assign wr_room    = wr_cnt_q < CNT_W'(MAX_WR_OUTSTANDING);
    assign in_ARREADY = ar_pipe_ready && rd_room;
    assign in_AWREADY = aw_pipe_ready && wr_room;
    assign ar_s_valid = in_ARVALID && rd_room;
    assign aw_s_valid = in_AWVALID && wr_room;

    axi_slice_chain #(.WIDTH(AX_W), .LEVEL(AW_LEVEL)) u_aw (
        .clk(ap_clk), .rst_n(ap_rst_n),
        .s_valid(aw_s_valid), .s_ready(aw_pipe_ready),
        .s_data({in_AWADDR, in_AWID, in_AWLEN, in_AWSIZE, in_AWBURST}),
        .m_valid(out_AWVALID), .m_ready(out_AWREADY),
        .m_data({out_AWADDR, out_AWID, out_AWLEN, out_AWSIZE, out_AWBURST}),
        .empty(aw_empty)
    );

    axi_slice_chain #(.WIDTH(W_W), .LEVEL(W_LEVEL)) u_w (
        .clk(ap_clk), .rst_n(ap_rst_n),
        .s_valid(in_WVALID), .s_ready(in_WREADY),
        .s_data({in_WDATA, in_WSTRB, in_WLAST}),
        .m_valid(out_WVALID), .m_ready(out_WREADY),
        .m_data({out_WDATA, out_WSTRB, out_WLAST}),
        .empty(w_empty)
    );

    axi_slice_chain #(.WIDTH(AX_W), .LEVEL(AR_LEVEL)) u_ar (
        .clk(ap_clk), .rst_n(ap_rst_n),
        .s_valid(ar_s_valid), .s_ready(ar_pipe_ready),
        .s_data({in_ARADDR, in_ARID, in_ARLEN, in_ARSIZE, in_ARBURST}),
        .m_valid(out_ARVALID), .m_ready(out_ARREADY),
        .m_data({out_ARADDR, out_ARID, out_ARLEN, out_ARSIZE, out_ARBURST}),
        .empty(ar_empty)
    );

    axi_slice_chain #(.WIDTH(R_W), .LEVEL(R_LEVEL)) u_r (
        .clk(ap_clk), .rst_n(ap_rst_n),
        .s_valid(out_RVALID), .s_ready(out_RREADY),
        .s_data({out_RDATA, out_RLAST, out_RID, out_RRESP}),
        .m_valid(in_RVALID), .m_ready(in_RREADY),
        .m_data({in_RDATA, in_RLAST, in_RID, in_RRESP}),
        .empty(r_empty)
    );

    axi_slice_chain #(.WIDTH(B_W), .LEVEL(B_LEVEL)) u_b (
        .clk(ap_clk), .rst_n(ap_rst_n),
        .s_valid(out_BVALID), .s_ready(out_BREADY),
        .s_data({out_BRESP, out_BID}),
        .m_valid(in_BVALID), .m_ready(in_BREADY),
        .m_data({in_BRESP, in_BID}),
        .empty(b_empty)
    );

    assign rd_nxt = cnt_next(rd_cnt_q, in_ARVALID && in_ARREADY, in_RVALID && in_RREADY && in_RLAST);
    assign wr_nxt = cnt_next(wr_cnt_q, in_AWVALID && in_AWREADY, in_BVALID && in_BREADY);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            rd_cnt_q <= rd_nxt[CNT_W-1:0];
            wr_cnt_q <= wr_nxt[CNT_W-1:0];
            err_q    <= err_q || rd_nxt[CNT_W] || wr_nxt[CNT_W];
            idle_q   <= aw_empty && w_empty && ar_empty && r_empty && b_empty &&
                        (rd_cnt_q == '0) && (wr_cnt_q == '0);
        end
    end

    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;
    assign idle           = idle_q;
    assign err_underflow  = err_q;
endmodule

// File: tb/tb_axi_pipeline_ot.sv
// tb/tb_axi_pipeline_ot.sv - directed self-checking bench for axi_pipeline_ot
module tb_axi_pipeline_ot;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int AW = 32;
    localparam int IW = 1;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic          in_AWVALID = 0, in_AWREADY;
    logic [AW-1:0] in_AWADDR = '0;
    logic [1:0]    in_AWBURST = '0;
    logic [7:0]    in_AWLEN = '0;
    logic [2:0]    in_AWSIZE = '0;
    logic [IW-1:0] in_AWID = '0;
    logic          in_WVALID = 0, in_WREADY;
    logic [DW-1:0] in_WDATA = '0;
    logic [SW-1:0] in_WSTRB = '0;
    logic          in_WLAST = 0;
    logic          in_BVALID, in_BREADY = 1;
    logic [1:0]    in_BRESP;
    logic [IW-1:0] in_BID;
    logic          in_ARVALID = 0, in_ARREADY;
    logic [AW-1:0] in_ARADDR = '0;
    logic [1:0]    in_ARBURST = '0;
    logic [7:0]    in_ARLEN = '0;
    logic [2:0]    in_ARSIZE = '0;
    logic [IW-1:0] in_ARID = '0;
    logic          in_RVALID, in_RREADY = 1;
    logic [DW-1:0] in_RDATA;
    logic          in_RLAST;
    logic [IW-1:0] in_RID;
    logic [1:0]    in_RRESP;
    logic          out_AWVALID, out_AWREADY = 1;
    logic [AW-1:0] out_AWADDR;
    logic [1:0]    out_AWBURST;
    logic [7:0]    out_AWLEN;
    logic [2:0]    out_AWSIZE;
    logic [IW-1:0] out_AWID;
    logic          out_WVALID, out_WREADY = 1;
    logic [DW-1:0] out_WDATA;
    logic [SW-1:0] out_WSTRB;
    logic          out_WLAST;
    logic          out_BVALID = 0, out_BREADY;
    logic [1:0]    out_BRESP = '0;
    logic [IW-1:0] out_BID = '0;
    logic          out_ARVALID, out_ARREADY = 1;
    logic [AW-1:0] out_ARADDR;
    logic [1:0]    out_ARBURST;
    logic [7:0]    out_ARLEN;
    logic [2:0]    out_ARSIZE;
    logic [IW-1:0] out_ARID;
    logic          out_RVALID = 0, out_RREADY;
    logic [DW-1:0] out_RDATA = '0;
    logic          out_RLAST = 0;
    logic [IW-1:0] out_RID = '0;
    logic [1:0]    out_RRESP = '0;
    logic [7:0]    rd_outstanding, wr_outstanding;
    logic          idle, err_underflow;

    axi_pipeline_ot #(
        .C_M_AXI_ID_WIDTH(IW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_WSTRB_WIDTH(SW), .AW_LEVEL(3), .W_LEVEL(3), .AR_LEVEL(3), .R_LEVEL(2),
        .B_LEVEL(3), .MAX_RD_OUTSTANDING(4), .MAX_WR_OUTSTANDING(4)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_AWVALID(in_AWVALID), .in_AWREADY(in_AWREADY), .in_AWADDR(in_AWADDR),
        .in_AWBURST(in_AWBURST), .in_AWLEN(in_AWLEN), .in_AWSIZE(in_AWSIZE), .in_AWID(in_AWID),
        .in_WVALID(in_WVALID), .in_WREADY(in_WREADY), .in_WDATA(in_WDATA), .in_WSTRB(in_WSTRB),
        .in_WLAST(in_WLAST),
        .in_BVALID(in_BVALID), .in_BREADY(in_BREADY), .in_BRESP(in_BRESP), .in_BID(in_BID),
        .in_ARVALID(in_ARVALID), .in_ARREADY(in_ARREADY), .in_ARADDR(in_ARADDR),
        .in_ARBURST(in_ARBURST), .in_ARLEN(in_ARLEN), .in_ARSIZE(in_ARSIZE), .in_ARID(in_ARID),
        .in_RVALID(in_RVALID), .in_RREADY(in_RREADY), .in_RDATA(in_RDATA), .in_RLAST(in_RLAST),
        .in_RID(in_RID), .in_RRESP(in_RRESP),
        .out_AWVALID(out_AWVALID), .out_AWREADY(out_AWREADY), .out_AWADDR(out_AWADDR),
        .out_AWBURST(out_AWBURST), .out_AWLEN(out_AWLEN), .out_AWSIZE(out_AWSIZE),
        .out_AWID(out_AWID),
        .out_WVALID(out_WVALID), .out_WREADY(out_WREADY), .out_WDATA(out_WDATA),
        .out_WSTRB(out_WSTRB), .out_WLAST(out_WLAST),
        .out_BVALID(out_BVALID), .out_BREADY(out_BREADY), .out_BRESP(out_BRESP), .out_BID(out_BID),
        .out_ARVALID(out_ARVALID), .out_ARREADY(out_ARREADY), .out_ARADDR(out_ARADDR),
        .out_ARBURST(out_ARBURST), .out_ARLEN(out_ARLEN), .out_ARSIZE(out_ARSIZE),
        .out_ARID(out_ARID),
        .out_RVALID(out_RVALID), .out_RREADY(out_RREADY), .out_RDATA(out_RDATA),
        .out_RLAST(out_RLAST), .out_RID(out_RID), .out_RRESP(out_RRESP),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .idle(idle), .err_underflow(err_underflow)
    );

    int passes = 0;
    int total  = 0;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int  tx, rx, acc_ar, acc_aw;
        bit  acc, seen_r, seen_b;
        logic [1:0]    b_resp;
        logic [IW-1:0] b_id;

        // Reset held 3 cycles with AW offered
        #1;
        in_AWVALID = 1'b1;
        in_AWADDR  = 32'h1234_5678;
        step(); step(); step();
        chk("rst_out_awvalid", out_AWVALID, 1'b0);
        chk("rst_in_rvalid", in_RVALID, 1'b0);
        chk("rst_in_bvalid", in_BVALID, 1'b0);
        in_AWVALID = 1'b0;
        ap_rst_n   = 1'b1;
        step();
        chk("post_rst_out_awvalid", out_AWVALID, 1'b0);
        chk("post_rst_rd_cnt", rd_outstanding, 8'd0);
        chk("post_rst_wr_cnt", wr_outstanding, 8'd0);
        chk("post_rst_idle", idle, 1'b1);
        chk("post_rst_err", err_underflow, 1'b0);
        chk("post_rst_wready", in_WREADY, 1'b1);
        chk("post_rst_arready", in_ARREADY, 1'b1);
        chk("post_rst_awready", in_AWREADY, 1'b1);

        // Unstalled W stream: beat c appears at out three cycles later
        in_WSTRB = 4'hA;
        for (int c = 0; c < 260; c++) begin
            if (c < 256) begin
                in_WVALID = 1'b1;
                in_WDATA  = 32'(c);
                in_WLAST  = (c % 16 == 15);
                chk("w_stream_wready", in_WREADY, 1'b1);
            end else begin
                in_WVALID = 1'b0;
            end
            if (c >= 3 && c < 259) begin
                chk("w_stream_valid", out_WVALID, 1'b1);
                chk("w_stream_data", out_WDATA, 64'(c - 3));
                chk("w_stream_last", out_WLAST, ((c - 3) % 16 == 15));
            end
            if (c == 259) chk("w_stream_drained", out_WVALID, 1'b0);
            step();
        end
        chk("w_stream_strb", out_WSTRB, 4'hA);

        // Random backpressure on W, in-order scoreboard
        tx = 0; rx = 0; acc = 1'b0;
        for (int k = 0; k < 5000 && rx < 500; k++) begin
            if (!in_WVALID || acc) begin
                in_WVALID = (tx < 500) && ($urandom_range(1) == 1);
                in_WDATA  = 32'(tx);
                in_WLAST  = 1'b0;
            end
            out_WREADY = ($urandom_range(1) == 1);
            acc = in_WVALID && in_WREADY;
            if (acc) tx++;
            if (out_WVALID && out_WREADY) begin
                chk("w_random_order", out_WDATA, 64'(rx));
                rx++;
            end
            step();
        end
        in_WVALID  = 1'b0;
        out_WREADY = 1'b1;
        chk("w_random_count", 64'(rx), 64'd500);

        // Read limiter: 4 ARs accepted while R is withheld
        in_ARADDR = 32'hA5A5_0010; in_ARLEN = 8'h0F; in_ARSIZE = 3'd2;
        in_ARBURST = 2'b01; in_ARID = 1'b1; in_ARVALID = 1'b1;
        acc_ar = 0;
        for (int k = 0; k < 10; k++) begin
            if (in_ARVALID && in_ARREADY) acc_ar++;
            if (k == 4) begin
                chk("ar_out_valid", out_ARVALID, 1'b1);
                chk("ar_out_payload", {out_ARADDR, out_ARID, out_ARLEN, out_ARSIZE, out_ARBURST},
                    {32'hA5A5_0010, 1'b1, 8'h0F, 3'd2, 2'b01});
            end
            step();
        end
        chk("rd_limit_accepted", 64'(acc_ar), 64'd4);
        chk("rd_limit_count", rd_outstanding, 8'd4);
        chk("rd_limit_arready", in_ARREADY, 1'b0);
        chk("rd_limit_not_idle", idle, 1'b0);

        chk("r_out_ready", out_RREADY, 1'b1);
        out_RVALID = 1'b1; out_RLAST = 1'b1; out_RDATA = 32'hDEAD_BEEF;
        out_RRESP = 2'b01; out_RID = 1'b1; in_RREADY = 1'b1;
        step();
        out_RVALID = 1'b0;
        seen_r = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (in_RVALID) begin
                seen_r = 1'b1;
                chk("r_payload", {in_RDATA, in_RLAST, in_RID, in_RRESP},
                    {32'hDEAD_BEEF, 1'b1, 1'b1, 2'b01});
            end
            if (in_ARVALID && in_ARREADY) acc_ar++;
            step();
        end
        chk("r_seen", seen_r, 1'b1);
        chk("rd_fifth_accepted", 64'(acc_ar), 64'd5);
        chk("rd_refill_count", rd_outstanding, 8'd4);

        // At MAX with RLAST handshake in the same cycle: AR must still be refused
        in_RREADY = 1'b0;
        out_RVALID = 1'b1;
        step();
        out_RVALID = 1'b0;
        for (int k = 0; k < 12 && !in_RVALID; k++) step();
        chk("r_held_valid", in_RVALID, 1'b1);
        chk("rd_at_max", rd_outstanding, 8'd4);
        in_RREADY = 1'b1;
        chk("rd_same_cycle_arready", in_ARREADY, 1'b0);
        step();
        in_RREADY = 1'b0;
        chk("rd_after_dec", rd_outstanding, 8'd3);
        chk("rd_reopen_arready", in_ARREADY, 1'b1);
        step();
        in_ARVALID = 1'b0;
        chk("rd_refilled", rd_outstanding, 8'd4);

        // Spurious B with no write outstanding
        chk("b_out_ready", out_BREADY, 1'b1);
        in_BREADY = 1'b1; out_BVALID = 1'b1; out_BRESP = 2'b10; out_BID = 1'b1;
        step();
        out_BVALID = 1'b0;
        seen_b = 1'b0; b_resp = '0; b_id = '0;
        for (int k = 0; k < 12 && !err_underflow; k++) begin
            if (in_BVALID) begin
                seen_b = 1'b1; b_resp = in_BRESP; b_id = in_BID;
            end
            step();
        end
        chk("b_seen", seen_b, 1'b1);
        chk("b_payload", {b_resp, b_id}, {2'b10, 1'b1});
        chk("underflow_set", err_underflow, 1'b1);
        chk("underflow_wr_cnt", wr_outstanding, 8'd0);
        step(); step();
        chk("underflow_sticky", err_underflow, 1'b1);

        // Write limiter, then reset with traffic in flight
        in_AWVALID = 1'b1; in_AWADDR = 32'h0000_0100; acc_aw = 0;
        out_AWREADY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (in_AWVALID && in_AWREADY) acc_aw++;
            step();
        end
        chk("wr_limit_accepted", 64'(acc_aw), 64'd4);
        chk("wr_limit_count", wr_outstanding, 8'd4);
        chk("wr_limit_awready", in_AWREADY, 1'b0);
        out_WREADY = 1'b0; in_WVALID = 1'b1; in_WDATA = 32'h5555_0000;
        step(); step(); step(); step();
        chk("mid_burst_wvalid", out_WVALID, 1'b1);
        ap_rst_n = 1'b0;
        step(); step();
        ap_rst_n = 1'b1; in_WVALID = 1'b0; in_AWVALID = 1'b0;
        step();
        chk("rst2_err", err_underflow, 1'b0);
        chk("rst2_rd_cnt", rd_outstanding, 8'd0);
        chk("rst2_wr_cnt", wr_outstanding, 8'd0);
        chk("rst2_out_wvalid", out_WVALID, 1'b0);
        chk("rst2_in_wready", in_WREADY, 1'b1);
        chk("rst2_arready", in_ARREADY, 1'b1);
        chk("rst2_awready", in_AWREADY, 1'b1);
        chk("rst2_idle", idle, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
